system_0_cpu_0_oci_dct_packer: RTL and testbench
================================================

# system_0_cpu_0_oci_dct_packer

Trace-side packer for the Nios II OCI debug control trace (DCT) path. It accumulates 2-bit trace atoms from the CPU trace port into a 30-bit DCT buffer with a 4-bit atom count, and commits full or flushed buffers as 34-bit trace words over a valid/ready interface to the trace memory writer. It also exposes the live buffer and count so the OCI test-bench monitor can observe them directly.

## Interface
Parameters:
- none; widths are fixed: 15 atoms × 2 bits = 30-bit buffer, 4-bit count.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- atom_valid  in  1  trace atom offered this cycle. The CPU never stalls for trace.
- atom  in  2  trace atom value.
- flush  in  1  single-cycle request to commit a partial buffer.
- atom_ready  out  1  combinational: `(dct_count < 15) && !flush_pending`.
- out_valid  out  1  trace word held in the output register.
- out_data  out  34  `{count[3:0], buffer[29:0]}` of the committed word.
- out_ready  in  1  downstream accepts the word when `out_valid && out_ready`.
- dct_buffer  out  30  live accumulation buffer.
- dct_count  out  4  live atom count, 0..15.
- drop_count  out  16  dropped-atom counter; see Configuration.

## Operation
- Atom accept:
  - An atom is accepted when `atom_valid && atom_ready`.
  - On accept, `dct_buffer <= {dct_buffer[27:0], atom}`: the newest atom goes to the LSBs.
  - On accept, `dct_count <= dct_count + 1`.
- Drop: an atom offered while `atom_ready` is 0 is lost. The buffer and count are unchanged.
- Flush:
  - `flush` sets `flush_pending` when `dct_count` is nonzero or an atom is accepted in the same cycle. Otherwise the flush is ignored.
  - An atom accepted in the same cycle as `flush` is included in the flushed word.
- Commit request: `commit_req = (dct_count == 15) || flush_pending`.
- Commit:
  - A commit occurs when `commit_req && (!out_valid || out_ready)`.
  - The commit loads `out_data <= {dct_count, dct_buffer}` and sets `out_valid <= 1`.
  - The commit clears `dct_buffer` and `dct_count` to 0 and clears `flush_pending`.
  - The buffer is not right-justified. Unused upper bits of a partial word are 0.
- Output register:
  - A handshake with no commit in the same cycle clears `out_valid`.
  - A handshake with a commit in the same cycle reloads the register back-to-back, so `out_valid` stays 1.
  - `out_data` is stable while `out_valid && !out_ready`.
- Implicit states: ACCUM (`count < 15`, no pending flush), COMMIT_WAIT (`commit_req` asserted, output register busy) and HOLD (`out_valid` asserted). ACCUM and HOLD coexist.
- Reset values:
  - `out_valid` 0, `out_data` 0.
  - `dct_buffer` 0, `dct_count` 0.
  - `flush_pending` 0, `drop_count` 0.
  - `atom_ready` is 1 in the first cycle after reset.
- Reset mid-operation: the partial buffer, a pending flush and any held word are discarded. No word is emitted.

## Timing
- Latency: 15th atom accepted at edge N; `dct_count` = 15 after N; commit at edge N+1; `out_valid` = 1 after N+1 if the output register is free.
- Flush latency: flush at edge N; `flush_pending` after N; commit at edge N+1 if the output register is free.
- Throughput:
  - With `out_ready` held high, the block sustains 15 atoms per 16 cycles.
  - `atom_ready` is low for the single commit cycle.
  - Under backpressure, `atom_ready` stays low from count 15 or `flush_pending` until the commit.
- Count wrap-around is impossible: accepts are blocked at 15.

## Configuration
- Macro `SYSTEM_0_CPU_0_OCI_DCT_DROP_CNT_EN`.
- Defined:
  - `drop_count` increments on each cycle with `atom_valid && !atom_ready`.
  - It saturates at 16'hFFFF and clears only on `reset`.
- Undefined: `drop_count` is tied to 16'h0000 and no counter register is built.

## Test plan
- Full word, free output:
  - Stimulus: reset, `out_ready` = 1, 15 consecutive atoms of 2'b01.
  - Response: at edge 16, `out_data` = 34'h3D5555555 and `out_valid` = 1 for one cycle.
  - Response: `atom_ready` is low in cycle 16 only, and `dct_count` returns to 0.
- Partial flush:
  - Stimulus: atoms 2'b11, 2'b10, 2'b01, then `flush`.
  - Response: `out_data` = 34'h0C0000039.
  - Stimulus: `flush` again with `dct_count` = 0.
  - Response: no word is emitted.
- Flush with same-cycle atom:
  - Stimulus: 2 atoms of 2'b10, then a third 2'b11 together with `flush`.
  - Response: `out_data` = 34'h0C000002B.
- Backpressure with drops, macro defined:
  - Stimulus: `out_ready` = 0; 15 atoms of 2'b00 (word 1 held); 15 atoms of 2'b01 (count reaches 15); 5 further atom_valid cycles.
  - Response: `drop_count` = 5; word 1 = 34'h3C0000000 stays stable.
  - Stimulus: release `out_ready`.
  - Response: word 1 is accepted, then 34'h3D5555555 follows on the next cycle.
- Reset mid-word:
  - Stimulus: 7 atoms, then `reset` for 1 cycle.
  - Response: `dct_count` = 0, `dct_buffer` = 0, no `out_valid`.
  - Stimulus: 15 new atoms.
  - Response: exactly one word is produced.
- Macro undefined: repeat the backpressure stimulus; `drop_count` stays 0.

Source files
------------

// File: rtl/system_0_cpu_0_oci_dct_packer.sv
// ---------------------------------------------------------------------------
// system_0_cpu_0_oci_dct_packer
//
// Packs 2-bit CPU trace atoms into a 30-bit DCT buffer (15 atoms) with a
// 4-bit atom count, and commits full or flushed buffers as 34-bit trace
// words {count, buffer} through a single-entry valid/ready output register.
// The live buffer and count are exported for the OCI monitor.
//
// Optional feature: define SYSTEM_0_CPU_0_OCI_DCT_DROP_CNT_EN to build a
// saturating 16-bit counter of atoms lost while atom_ready is low. Without
// it, drop_count is tied to zero.
//
// Ports:
//   clk         in   1   system clock, rising edge
//   reset       in   1   synchronous active-high reset
//   atom_valid  in   1   trace atom offered (CPU never stalls)
//   atom        in   2   trace atom value
//   flush       in   1   single-cycle request to commit a partial buffer
//   atom_ready  out  1   buffer can take an atom this cycle
//   out_valid   out  1   trace word held in the output register
//   out_data    out  34  {count, buffer} of the committed word
//   out_ready   in   1   downstream accepts the held word
//   dct_buffer  out  30  live accumulation buffer
//   dct_count   out  4   live atom count, 0..15
//   drop_count  out  16  dropped-atom counter (zero when feature disabled)
// ---------------------------------------------------------------------------
module system_0_cpu_0_oci_dct_packer (
   input  logic        clk,
   input  logic        reset,
   input  logic        atom_valid,
   input  logic [1:0]  atom,
   input  logic        flush,
   output logic        atom_ready,
   output logic        out_valid,
   output logic [33:0] out_data,
   input  logic        out_ready,
   output logic [29:0] dct_buffer,
   output logic [3:0]  dct_count,
   output logic [15:0] drop_count
);

   localparam logic [3:0] FULL_COUNT = 4'd15;

   logic [29:0] buffer_reg;
   logic [3:0]  count_reg;
   logic        flush_pending_reg;
   logic        out_valid_reg;
   logic [33:0] out_data_reg;

   logic accept;
   logic commit_req;
   logic commit;
   logic handshake;

   // atom_ready is exactly !commit_req, so an accept and a commit can never
   // happen in the same cycle.
   assign commit_req = (count_reg == FULL_COUNT) || flush_pending_reg;
   assign atom_ready = (count_reg < FULL_COUNT) && !flush_pending_reg;
   assign accept     = atom_valid && atom_ready;
   assign handshake  = out_valid_reg && out_ready;
   assign commit     = commit_req && (!out_valid_reg || out_ready);

   // Accumulation buffer, count and flush request.
   always_ff @(posedge clk) begin
      if (reset) begin
         buffer_reg        <= '0;
         count_reg         <= '0;
         flush_pending_reg <= 1'b0;
      end else if (commit) begin
         // A flush arriving on a commit cycle finds its data already in the
         // committed word, so the clear wins over a new request.
         buffer_reg        <= '0;
         count_reg         <= '0;
         flush_pending_reg <= 1'b0;
      end else begin
         if (accept) begin
            buffer_reg <= {buffer_reg[27:0], atom};
            count_reg  <= count_reg + 4'd1;
         end
         // Flushing an empty buffer would emit an empty word; ignore it.
         if (flush && ((count_reg != 4'd0) || accept)) begin
            flush_pending_reg <= 1'b1;
         end
      end
   end

   // Single-entry output register; reloads back-to-back on handshake+commit.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
      end else if (commit) begin
         out_valid_reg <= 1'b1;
         out_data_reg  <= {count_reg, buffer_reg};
      end else if (handshake) begin
         out_valid_reg <= 1'b0;
      end
   end

   assign out_valid  = out_valid_reg;
   assign out_data   = out_data_reg;
   assign dct_buffer = buffer_reg;
   assign dct_count  = count_reg;

`ifdef SYSTEM_0_CPU_0_OCI_DCT_DROP_CNT_EN
   logic [15:0] drop_count_reg;

   // Saturating count of atoms offered while the buffer could not take them.
   always_ff @(posedge clk) begin
      if (reset) begin
         drop_count_reg <= '0;
      end else if (atom_valid && !atom_ready && (drop_count_reg != 16'hFFFF)) begin
         drop_count_reg <= drop_count_reg + 16'd1;
      end
   end

   assign drop_count = drop_count_reg;
`else
   assign drop_count = 16'h0000;
`endif

endmodule

// File: tb/tb_system_0_cpu_0_oci_dct_packer.sv
// ---------------------------------------------------------------------------
// tb_system_0_cpu_0_oci_dct_packer
//
// Scoreboard bench: each test pushes the trace words it expects onto a
// queue while driving atoms; a monitor pops and compares a word on every
// out_valid && out_ready handshake. Inputs are driven 1 time unit after the
// rising edge; DUT outputs are sampled on the falling edge or #1 after the
// rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_system_0_cpu_0_oci_dct_packer;

   logic        clk = 1'b0;
   logic        reset;
   logic        atom_valid;
   logic [1:0]  atom;
   logic        flush;
   logic        atom_ready;
   logic        out_valid;
   logic [33:0] out_data;
   logic        out_ready;
   logic [29:0] dct_buffer;
   logic [3:0]  dct_count;
   logic [15:0] drop_count;

   int checks = 0;
   int errors = 0;
   logic [33:0] exp_q[$];

`ifdef SYSTEM_0_CPU_0_OCI_DCT_DROP_CNT_EN
   localparam logic [15:0] DROP_EXP = 16'd5;
`else
   localparam logic [15:0] DROP_EXP = 16'd0;
`endif

   always #5 clk = ~clk;

   system_0_cpu_0_oci_dct_packer dut (
      .clk        (clk),
      .reset      (reset),
      .atom_valid (atom_valid),
      .atom       (atom),
      .flush      (flush),
      .atom_ready (atom_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .dct_buffer (dct_buffer),
      .dct_count  (dct_count),
      .drop_count (drop_count)
   );

   task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end else begin
         $display("ok   %s: %h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for atom_ready, then present one atom for one edge.
   task automatic send_atom(input logic [1:0] a);
      int waited = 0;
      while (!atom_ready && waited < 50) begin
         tick();
         waited++;
      end
      if (!atom_ready) check("atom_ready_timeout", {33'd0, atom_ready}, 34'd1);
      atom_valid = 1'b1;
      atom       = a;
      tick();
      atom_valid = 1'b0;
   endtask

   // Scoreboard monitor: one comparison per handshake.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_word_qsize", 34'(exp_q.size()), 34'd1);
         end else begin
            check("sb_word", out_data, exp_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation timed out");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [29:0] mbuf;
      reset = 1'b1; atom_valid = 1'b0; atom = 2'b00; flush = 1'b0; out_ready = 1'b0;
      tick(); tick();
      reset = 1'b0;
      // ---- reset state ----
      check("rst_out_valid",  {33'd0, out_valid}, 34'd0);
      check("rst_out_data",   out_data, 34'd0);
      check("rst_dct_count",  {30'd0, dct_count}, 34'd0);
      check("rst_dct_buffer", {4'd0, dct_buffer}, 34'd0);
      check("rst_atom_ready", {33'd0, atom_ready}, 34'd1);
      check("rst_drop_count", {18'd0, drop_count}, 34'd0);

      // ---- full word, free output ----
      out_ready = 1'b1;
      exp_q.push_back(34'h3D5555555);
      for (int i = 0; i < 15; i++) send_atom(2'b01);
      check("full_count15",   {30'd0, dct_count}, 34'd15);
      check("full_ready_low", {33'd0, atom_ready}, 34'd0);
      tick();
      check("full_out_valid", {33'd0, out_valid}, 34'd1);
      check("full_out_data",  out_data, 34'h3D5555555);
      check("full_count0",    {30'd0, dct_count}, 34'd0);
      check("full_ready_back",{33'd0, atom_ready}, 34'd1);
      tick();
      check("full_valid_1cyc",{33'd0, out_valid}, 34'd0);

      // ---- partial flush ----
      exp_q.push_back(34'h0C0000039);
      send_atom(2'b11); send_atom(2'b10); send_atom(2'b01);
      flush = 1'b1; tick(); flush = 1'b0;
      check("flush_ready_low", {33'd0, atom_ready}, 34'd0);
      tick();
      check("flush_out_data", out_data, 34'h0C0000039);
      tick();
      // flush with an empty buffer: nothing must come out
      flush = 1'b1; tick(); flush = 1'b0;
      tick(); tick();
      check("empty_flush_no_word", {33'd0, out_valid}, 34'd0);

      // ---- flush with same-cycle atom ----
      exp_q.push_back(34'h0C000002B);
      send_atom(2'b10); send_atom(2'b10);
      atom_valid = 1'b1; atom = 2'b11; flush = 1'b1;
      tick();
      atom_valid = 1'b0; flush = 1'b0;
      tick();
      check("samecyc_out_data", out_data, 34'h0C000002B);
      tick(); tick();

      // ---- backpressure with drops ----
      out_ready = 1'b0;
      exp_q.push_back(34'h3C0000000);
      exp_q.push_back(34'h3D5555555);
      for (int i = 0; i < 15; i++) send_atom(2'b00);
      for (int i = 0; i < 15; i++) send_atom(2'b01);
      check("bp_count15",   {30'd0, dct_count}, 34'd15);
      check("bp_ready_low", {33'd0, atom_ready}, 34'd0);
      atom_valid = 1'b1; atom = 2'b10;
      repeat (5) tick();
      atom_valid = 1'b0;
      check("bp_drop_count", {18'd0, drop_count}, {18'd0, DROP_EXP});
      check("bp_count_kept", {30'd0, dct_count}, 34'd15);
      for (int i = 0; i < 3; i++) begin
         check("bp_hold_valid", {33'd0, out_valid}, 34'd1);
         check("bp_hold_data",  out_data, 34'h3C0000000);
         tick();
      end
      out_ready = 1'b1;
      tick();
      check("bp_b2b_valid", {33'd0, out_valid}, 34'd1);
      check("bp_b2b_data",  out_data, 34'h3D5555555);
      tick();
      check("bp_drained",   {33'd0, out_valid}, 34'd0);

      // ---- reset mid-word ----
      for (int i = 0; i < 7; i++) send_atom(2'(i));
      reset = 1'b1; tick(); reset = 1'b0;
      check("mid_rst_count",  {30'd0, dct_count}, 34'd0);
      check("mid_rst_buffer", {4'd0, dct_buffer}, 34'd0);
      check("mid_rst_valid",  {33'd0, out_valid}, 34'd0);
      mbuf = '0;
      for (int i = 0; i < 15; i++) mbuf = {mbuf[27:0], 2'(i + 1)};
      exp_q.push_back({4'd15, mbuf});
      for (int i = 0; i < 15; i++) send_atom(2'(i + 1));
      repeat (4) tick();
      check("sb_drain_qsize", 34'(exp_q.size()), 34'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
